// File: rtl/a_mux_serial_16v1.sv
// -----------------------------------------------------------------------------
// a_mux_serial_16v1
//   Parallel-to-serial transmitter for the serial management link. WIDTH-bit
//   words are shifted onto a 1-bit line LSB first, one bit per clk_emit strobe.
//   The strobe is a clock-enable sampled on clk_ref, not a clock.
//   Frames are contiguous and slot-aligned from reset: the line never stops.
//   A frame with no user word carries IDLE_WORD.
//
// Ports
//   clk_ref   in   1      system clock, all logic on posedge
//   rst_n     in   1      asynchronous active-low reset
//   clk_emit  in   1      bit strobe; one slot advances per cycle it is high
//   t_d       in   WIDTH  parallel word to send
//   t_dv      in   1      t_d valid; accepted when t_dv & t_rdy
//   t_rdy     out  1      holding register empty
//   t_do      out  1      serial data out (registered)
//   t_sof     out  1      high while t_do carries slot 0 of a frame
//   t_busy    out  1      current frame carries user data
//   t_udr     out  1      one-cycle pulse when a data frame is followed by idle
// -----------------------------------------------------------------------------
module a_mux_serial_16v1 #(
    parameter int                WIDTH     = 16,
    parameter logic [WIDTH-1:0]  IDLE_WORD = {WIDTH{1'b0}}
) (
    input  logic              clk_ref,
    input  logic              rst_n,
    input  logic              clk_emit,
    input  logic [WIDTH-1:0]  t_d,
    input  logic              t_dv,
    output logic              t_rdy,
    output logic              t_do,
    output logic              t_sof,
    output logic              t_busy,
    output logic              t_udr
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_hold_q;
    logic              r_hold_v;
    logic [WIDTH-1:0]  r_sh_q;
    logic [CW-1:0]     r_cpt;
    logic              r_do;
    logic              r_sof;
    logic              r_udr;

    logic              w_accept;
    logic              w_load;
    logic [WIDTH-1:0]  w_word;
    logic [CW-1:0]     w_cpt_nxt;

    // Accept only into an empty holding register; a pending word is never
    // overwritten, the source keeps t_dv up until it is taken.
    assign w_accept  = t_dv & ~r_hold_v;

    // Slot-0 strobe loads a whole frame.
    assign w_load    = clk_emit & (r_cpt == '0);

    // Frame content: pending user word, else the idle pattern. A word arriving
    // on the very same edge is not bypassed; it waits for the next frame.
    assign w_word    = r_hold_v ? r_hold_q : IDLE_WORD;

    assign w_cpt_nxt = (r_cpt == LAST_SLOT) ? '0 : r_cpt + CW'(1);

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_hold_q <= '0;
            r_hold_v <= 1'b0;
            r_sh_q   <= '0;
            r_cpt    <= '0;
            r_do     <= 1'b0;
            r_sof    <= 1'b0;
            r_udr    <= 1'b0;
        end else begin
            // Underrun is a single-cycle pulse; only a load can raise it.
            r_udr <= 1'b0;

            if (w_accept) begin
                r_hold_q <= t_d;
                r_hold_v <= 1'b1;
            end

            if (clk_emit) begin
                r_cpt <= w_cpt_nxt;
                if (w_load) begin
                    r_do   <= w_word[0];
                    r_sh_q <= w_word >> 1;
                    r_sof  <= 1'b1;
                    if (r_hold_v) begin
                        // Accept is blocked while hold is full, so this clear
                        // never races a same-cycle write.
                        r_hold_v <= 1'b0;
                        r_state  <= S_DATA;
                    end else begin
                        r_state  <= S_IDLE;
                        if (r_state == S_DATA)
                            r_udr <= 1'b1;
                    end
                end else begin
                    r_do   <= r_sh_q[0];
                    r_sh_q <= r_sh_q >> 1;
                    r_sof  <= 1'b0;
                end
            end
        end
    end

    assign t_rdy  = ~r_hold_v;
    assign t_do   = r_do;
    assign t_sof  = r_sof;
    assign t_busy = (r_state == S_DATA);
    assign t_udr  = r_udr;

endmodule

// File: tb/tb_a_mux_serial_16v1.sv
// -----------------------------------------------------------------------------
// tb_a_mux_serial_16v1
//   Directed bench for the serial transmitter. Inputs change and outputs are
//   sampled 1 ns after each rising clk_ref edge.
// -----------------------------------------------------------------------------
module tb_a_mux_serial_16v1;

    logic        clk_ref = 1'b0;
    logic        rst_n;
    logic        clk_emit;
    logic [15:0] t_d;
    logic        t_dv;
    logic        t_rdy;
    logic        t_do;
    logic        t_sof;
    logic        t_busy;
    logic        t_udr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_ref = ~clk_ref;

    a_mux_serial_16v1 #(
        .WIDTH     (16),
        .IDLE_WORD (16'h0000)
    ) dut (
        .clk_ref  (clk_ref),
        .rst_n    (rst_n),
        .clk_emit (clk_emit),
        .t_d      (t_d),
        .t_dv     (t_dv),
        .t_rdy    (t_rdy),
        .t_do     (t_do),
        .t_sof    (t_sof),
        .t_busy   (t_busy),
        .t_udr    (t_udr)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    // One full frame with a strobe every cycle. Optionally offers a word at a
    // given slot and drops t_dv once it is taken. rdy0 < 0 skips the t_rdy
    // check right after the load.
    task automatic frame(input string tag, input logic [15:0] exp_w,
                         input logic exp_busy, input logic exp_udr,
                         input logic offer, input logic [15:0] ow,
                         input int oslot, input int rdy0);
        logic acc;
        clk_emit = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (offer && i == oslot) begin
                t_d  = ow;
                t_dv = 1'b1;
            end
            acc = t_dv & t_rdy;
            tick();
            if (acc) t_dv = 1'b0;
            chk($sformatf("%s do[%0d]", tag, i), t_do, exp_w[i]);
            chk($sformatf("%s sof[%0d]", tag, i), t_sof, i == 0);
            chk($sformatf("%s busy[%0d]", tag, i), t_busy, exp_busy);
            chk($sformatf("%s udr[%0d]", tag, i), t_udr, (i == 0) ? exp_udr : 1'b0);
            if (i == 0 && rdy0 >= 0)
                chk($sformatf("%s rdy_after_load", tag), t_rdy, rdy0 != 0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " do"},   t_do,   1'b0);
        chk({tag, " sof"},  t_sof,  1'b0);
        chk({tag, " busy"}, t_busy, 1'b0);
        chk({tag, " udr"},  t_udr,  1'b0);
        chk({tag, " rdy"},  t_rdy,  1'b1);
    endtask

    initial begin
        logic [15:0] w;
        rst_n    = 1'b0;
        clk_emit = 1'b0;
        t_d      = 16'h0000;
        t_dv     = 1'b0;
        tick();
        tick();
        chk_reset_vals("RST");
        rst_n = 1'b1;
        tick();

        // T1: A5C3 -> 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 ; 1234 offered mid-frame
        t_d  = 16'hA5C3;
        t_dv = 1'b1;
        tick();
        t_dv = 1'b0;
        chk("T1 rdy_while_held", t_rdy, 1'b0);
        chk("T1 do_no_strobe", t_do, 1'b0);
        frame("T1", 16'b1010_0101_1100_0011, 1'b1, 1'b0, 1'b1, 16'h1234, 5, 1);

        // T2: back-to-back data frames, FFFF offered mid-frame
        frame("T2a", 16'h1234, 1'b1, 1'b0, 1'b1, 16'hFFFF, 8, 1);
        frame("T2b", 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1);

        // T3: underrun pulse at first idle load only
        frame("T3a", 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 1);
        frame("T3b", 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 1);

        // T6: word offered on the slot-0 edge with hold empty -> idle frame,
        // word goes out in the following frame
        frame("T6a", 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00FF, 0, 0);
        chk("T6 rdy_before_load", t_rdy, 1'b0);
        frame("T6b", 16'h00FF, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 1);

        // T4: strobe every 4th cycle, 8001 -> each bit held 4 cycles
        clk_emit = 1'b0;
        t_d  = 16'h8001;
        t_dv = 1'b1;
        tick();
        t_dv = 1'b0;
        w = 16'h8001;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) begin
                clk_emit = (k == 0);
                tick();
                chk($sformatf("T4 do[%0d.%0d]", i, k), t_do, w[i]);
                chk($sformatf("T4 sof[%0d.%0d]", i, k), t_sof, i == 0);
            end
        end
        clk_emit = 1'b0;

        // T5: reset at slot 7 of BEEF with another word pending in hold
        t_d  = 16'hBEEF;
        t_dv = 1'b1;
        tick();
        t_dv = 1'b0;
        clk_emit = 1'b1;
        w = 16'hBEEF;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                t_d  = 16'hFFFF;
                t_dv = 1'b1;
            end
            tick();
            if (i == 3) t_dv = 1'b0;
            chk($sformatf("T5 do[%0d]", i), t_do, w[i]);
        end
        chk("T5 busy_pre", t_busy, 1'b1);
        chk("T5 rdy_pre", t_rdy, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("T5 async");
        tick();
        rst_n = 1'b1;
        tick();
        chk("T5 sof_first", t_sof, 1'b1);
        chk("T5 do_first", t_do, 1'b0);
        chk("T5 busy_first", t_busy, 1'b0);
        chk("T5 udr_first", t_udr, 1'b0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("T5 idle do[%0d]", i), t_do, 1'b0);
            chk($sformatf("T5 idle sof[%0d]", i), t_sof, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
